// File: rtl/fifo_drain_ctrl.sv
// FIFO read-side drain controller: bursts pops, retimes data to a stream.
// Optional rd_count statistics counter is built when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain_ctrl #(
  parameter int WORD_SIZE = 6,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [WORD_SIZE-1:0] fifo_data,
  input  logic                 pause,
  output logic                 fifo_rd,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic                 busy,
  output logic [CNT_W-1:0]     rd_count
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    STALL,
    GAP
  } state_t;

  localparam logic [3:0] LAST = 4'(BURST_LEN - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] burst_cnt;
  logic [3:0] burst_nx;
  logic       go;
  logic       rd_d1;

  assign go   = enable & ~fifo_empty & ~pause;
  assign busy = (state != IDLE);

  // State and burst counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      burst_cnt <= burst_nx;
    end
  end

  // Next state, burst accounting and the Mealy pop strobe
  always_comb begin
    state_nx = state;
    burst_nx = burst_cnt;
    fifo_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        burst_nx = '0;
        if (go) state_nx = DRAIN;
      end
      DRAIN: begin
        fifo_rd = go;
        if (go) burst_nx = burst_cnt + 4'd1;
        if (go && burst_cnt == LAST)
          state_nx = GAP;
        else if (!enable || fifo_empty)
          state_nx = IDLE;
        else if (pause)
          state_nx = STALL;
      end
      STALL: begin
        if (!enable || fifo_empty)
          state_nx = IDLE;
        else if (!pause)
          state_nx = DRAIN;
      end
      GAP: begin
        burst_nx = '0;
        state_nx = IDLE;
      end
      default: begin
        burst_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Two-stage retiming of the registered FIFO read port
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1     <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      rd_d1     <= fifo_rd;
      valid_out <= rd_d1;
      if (rd_d1) data_out <= fifo_data;
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Free-running pop counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (fifo_rd)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Testbench for fifo_drain_ctrl with a small behavioural FIFO.
// Expected rd_count follows FIFO_DRAIN_STATS_EN.
module tb_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pause = 1'b0;
  logic        push = 1'b0;
  logic [5:0]  push_data = '0;
  logic        fifo_empty;
  logic [5:0]  fifo_data = '0;
  logic        fifo_rd;
  logic [5:0]  data_out;
  logic        valid_out;
  logic        busy;
  logic [15:0] rd_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_drain_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .pause      (pause),
    .fifo_rd    (fifo_rd),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .busy       (busy),
    .rd_count   (rd_count)
  );

  logic [5:0] mem [32];
  logic [4:0] wp = '0;
  logic [4:0] rp = '0;
  int         count = 0;
  logic       err_seen = 1'b0;
  logic       pop;

  assign fifo_empty = (count == 0);
  assign pop = fifo_rd && (count > 0);

  always @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= 0;
      fifo_data <= '0;
      err_seen <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp <= wp + 5'd1;
      end
      if (pop) begin
        fifo_data <= mem[rp];
        rp <= rp + 5'd1;
      end
      if (fifo_rd && fifo_empty) err_seen <= 1'b1;
      count <= count + (push ? 1 : 0) - (pop ? 1 : 0);
    end
  end

  logic [5:0] got [$];

  always @(negedge clk) begin
    if (valid_out) got.push_back(data_out);
  end

  function automatic int exp_cnt(input int n);
`ifdef FIFO_DRAIN_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic e,
                       input logic p, input logic pu,
                       input logic [5:0] d);
    @(negedge clk);
    reset = r;
    enable = e;
    pause = p;
    push = pu;
    push_data = d;
    #1;
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 6'h00);
    apply(1, 0, 0, 0, 6'h00);
    got.delete();
  endtask

  task automatic load(input int n, input logic [5:0] base);
    for (int i = 0; i < n; i++)
      apply(0, 0, 0, 1, base + 6'(i));
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       pu;
    logic [5:0] d;
    logic       rd;
    logic       vld;
    logic [5:0] dout;
    logic       bsy;
    int         cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int n;
    int viol;
    int acc;
    int cur;
    int z;
    int runs [$];
    int gaps [$];
    logic tr [30];
    logic [5:0] exp_w;

    tbl[0] = '{1, 0, 0, 6'h00, 0, 0, 6'h00, 0, 0};
    tbl[1] = '{1, 0, 0, 6'h00, 0, 0, 6'h00, 0, 0};
    tbl[2] = '{0, 1, 1, 6'h01, 0, 0, 6'h00, 0, 0};
    tbl[3] = '{0, 1, 1, 6'h02, 0, 0, 6'h00, 0, 0};
    tbl[4] = '{0, 1, 1, 6'h03, 1, 0, 6'h00, 1, 0};
    tbl[5] = '{0, 1, 0, 6'h00, 1, 0, 6'h00, 1, 1};
    tbl[6] = '{0, 1, 0, 6'h00, 1, 1, 6'h01, 1, 2};
    tbl[7] = '{0, 1, 0, 6'h00, 0, 1, 6'h02, 1, 3};
    tbl[8] = '{0, 1, 0, 6'h00, 0, 1, 6'h03, 0, 3};
    tbl[9] = '{0, 1, 0, 6'h00, 0, 0, 6'h03, 0, 3};

    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].rst, tbl[i].en, 0, tbl[i].pu, tbl[i].d);
      check($sformatf("t%0d_rd", i), 32'(fifo_rd), 32'(tbl[i].rd));
      check($sformatf("t%0d_vld", i), 32'(valid_out), 32'(tbl[i].vld));
      check($sformatf("t%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
      check($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("t%0d_cnt", i), 32'(rd_count),
            32'(exp_cnt(tbl[i].cnt)));
    end

    // burst limit: 10 words -> 4,4,2 with two idle cycles between
    do_reset();
    load(10, 6'h10);
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      apply(0, 1, 0, 0, 6'h00);
      tr[i] = fifo_rd;
      if (fifo_rd && fifo_empty) viol++;
    end
    cur = 0;
    z = 0;
    for (int i = 0; i < 30; i++) begin
      if (tr[i]) begin
        if (cur == 0 && runs.size() > 0) gaps.push_back(z);
        cur++;
      end else begin
        if (cur > 0) begin
          runs.push_back(cur);
          cur = 0;
          z = 0;
        end
        z++;
      end
    end
    if (cur > 0) runs.push_back(cur);
    check("burst_runs", runs.size(), 3);
    check("burst_0", runs.size() > 0 ? runs[0] : -1, 4);
    check("burst_1", runs.size() > 1 ? runs[1] : -1, 4);
    check("burst_2", runs.size() > 2 ? runs[2] : -1, 2);
    check("gap_0", gaps.size() > 0 ? gaps[0] : -1, 2);
    check("gap_1", gaps.size() > 1 ? gaps[1] : -1, 2);
    check("burst_words", got.size(), 10);
    for (int i = 0; i < 10; i++) begin
      exp_w = 6'h10 + 6'(i);
      check($sformatf("burst_w%0d", i),
            i < got.size() ? 32'(got[i]) : 32'hffff_ffff,
            32'(exp_w));
    end
    check("burst_cnt", 32'(rd_count), 32'(exp_cnt(10)));
    check("burst_idle", 32'(busy), 0);
    check("burst_viol", viol, 0);

    // pause after two reads, stall, resume with two reads left
    do_reset();
    load(8, 6'h20);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      apply(0, 1, 0, 0, 6'h00);
      if (fifo_rd) n++;
    end
    check("pause_pre_rd", n, 2);
    apply(0, 1, 1, 0, 6'h00);
    check("pause_rd_now", 32'(fifo_rd), 0);
    check("pause_busy", 32'(busy), 1);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 1, 0, 6'h00);
      if (fifo_rd) acc++;
    end
    check("stall_no_rd", acc, 0);
    check("stall_busy", 32'(busy), 1);
    check("inflight_n", got.size(), 2);
    check("inflight_0", got.size() > 0 ? 32'(got[0]) : -1, 32'h20);
    check("inflight_1", got.size() > 1 ? 32'(got[1]) : -1, 32'h21);
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 0, 0, 6'h00);
      tr[i] = fifo_rd;
    end
    check("resume_0", 32'(tr[0]), 0);
    check("resume_1", 32'(tr[1]), 1);
    check("resume_2", 32'(tr[2]), 1);
    check("resume_gap", 32'(tr[3]), 0);
    check("resume_idle", 32'(tr[4]), 0);
    check("resume_next", 32'(tr[5]), 1);
    for (int i = 0; i < 10; i++) apply(0, 1, 0, 0, 6'h00);
    check("pause_words", got.size(), 8);
    check("pause_err", 32'(err_seen), 0);

    // FIFO runs dry mid-burst while words trickle in
    do_reset();
    viol = 0;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: apply(0, 1, 0, 1, 6'h31);
        1: apply(0, 1, 0, 1, 6'h32);
        5: apply(0, 1, 0, 1, 6'h33);
        default: apply(0, 1, 0, 0, 6'h00);
      endcase
      if (fifo_rd) acc++;
      if (fifo_rd && fifo_empty) viol++;
      if (i == 5) check("empty_to_idle", 32'(busy), 0);
    end
    for (int i = 0; i < 4; i++) apply(0, 1, 0, 0, 6'h00);
    check("empty_reads", acc, 3);
    check("empty_viol", viol, 0);
    check("empty_err", 32'(err_seen), 0);
    check("empty_busy", 32'(busy), 0);
    check("empty_words", got.size(), 3);
    check("empty_last", got.size() > 2 ? 32'(got[2]) : -1, 32'h33);
    check("empty_cnt", 32'(rd_count), 32'(exp_cnt(3)));

    // reset one cycle after a pop discards the in-flight word
    load(5, 6'h40);
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      apply(0, 1, 0, 0, 6'h00);
      if (fifo_rd) n++;
    end
    check("rst_saw_rd", n, 1);
    apply(1, 1, 0, 0, 6'h00);
    check("rst_pre_dout", 32'(data_out), 32'h33);
    check("rst_pre_cnt", 32'(rd_count), 32'(exp_cnt(4)));
    got.delete();
    apply(0, 0, 0, 0, 6'h00);
    check("rst_vld", 32'(valid_out), 0);
    check("rst_dout", 32'(data_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd", 32'(fifo_rd), 0);
    check("rst_cnt", 32'(rd_count), 0);
    apply(0, 0, 0, 0, 6'h00);
    apply(0, 0, 0, 0, 6'h00);
    check("rst_discard", got.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
